// File: rtl/step_pulse_gen.sv
// step_pulse_gen: single-cycle pipeline step enables from key, fast tick or slow tick
module step_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FAST_BIT        = 14,
  parameter int SLOW_BIT        = 19,
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                   clock_50,
  input  logic                   reset,
  input  logic                   key_n,
  input  logic [1:0]             select,
  input  logic                   halt_req,
  output logic                   step_en,
  output logic                   key_clean,
  output logic [COUNT_WIDTH-1:0] step_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]             r_sync;
  logic [DW-1:0]          r_db_cnt;
  logic                   r_key_clean;
  logic                   r_key_prev;
  logic [SLOW_BIT:0]      r_div;
  logic [1:0]             r_sel;
  logic                   r_step_en;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_key_s;
  logic                   w_key_rise;
  logic                   w_fast;
  logic                   w_slow;
  logic                   w_blank;
  logic                   w_src;
  assign w_key_s    = ~r_sync[1];
  assign w_key_rise = r_key_clean & ~r_key_prev;
  assign w_fast     = &r_div[FAST_BIT:0];
  assign w_slow     = &r_div;
  assign w_blank    = select != r_sel;
  assign w_src      = (r_sel == 2'b00) ? w_key_rise :
                      (r_sel == 2'b10) ? w_fast :
                      (r_sel == 2'b01) ? w_slow : 1'b0;
  assign step_en    = r_step_en;
  assign key_clean  = r_key_clean;
  assign step_count = r_count;
  // synchronize the raw button and accept a new level only after it holds long enough
  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_sync      <= 2'b11;
      r_db_cnt    <= '0;
      r_key_clean <= 1'b0;
      r_key_prev  <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], key_n};
      r_key_prev <= r_key_clean;
      if (w_key_s == r_key_clean) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        r_db_cnt    <= '0;
        r_key_clean <= w_key_s;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end
  // free-running divider feeding both tick sources
  always_ff @(posedge clock_50) begin
    if (reset) r_div <= '0;
    else       r_div <= r_div + 1'b1;
  end
  // register select and emit a one-cycle step; a select change blanks the cycle
  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_sel     <= 2'b00;
      r_step_en <= 1'b0;
    end else begin
      r_sel     <= select;
      r_step_en <= w_src & ~w_blank & ~halt_req & ~r_step_en;
    end
  end
  // count issued steps, wrapping silently
  always_ff @(posedge clock_50) begin
    if (reset)          r_count <= '0;
    else if (r_step_en) r_count <= r_count + 1'b1;
  end
endmodule
